// File: rtl/ysyx_24080006_mdu.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Optional macro YSYX_24080006_MDU_FAST_EN lets zero operands skip the iteration loop.
module ysyx_24080006_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [4:0]      mdu_set_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o
);

    typedef struct packed {
        logic       mdu_enable;
        logic       signed_a;
        logic       signed_b;
        logic [1:0] mdu_op;
    } mdu_set_t;

    typedef enum logic [1:0] {OP_MUL = 2'd0, OP_MULH = 2'd1, OP_DIV = 2'd2, OP_REM = 2'd3} mdu_op_e;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

    mdu_set_t set;
    state_e   state, state_nxt;
    logic     accept;
    logic     vld_q, vld_nxt;

    logic [1:0]  op;
    logic        neg_a, neg_b;
    logic [32:0] b_mag;
    logic [63:0] prod;
    logic [4:0]  cnt;
    logic [31:0] result_q;

    logic        neg_a_in, neg_b_in;
    logic [32:0] a_ext, b_ext, a_mag_in, b_mag_in;

    assign set    = mdu_set_i;
    assign accept = (state == IDLE) & in_valid_i & set.mdu_enable & ~flush_i;

    // Sign-extend before negating so 0x80000000 yields magnitude 2^31, not a wrapped value.
    assign neg_a_in = set.signed_a & rs1_i[31];
    assign neg_b_in = set.signed_b & rs2_i[31];
    assign a_ext    = {neg_a_in, rs1_i};
    assign b_ext    = {neg_b_in, rs2_i};
    assign a_mag_in = neg_a_in ? (33'd0 - a_ext) : a_ext;
    assign b_mag_in = neg_b_in ? (33'd0 - b_ext) : b_ext;

`ifdef YSYX_24080006_MDU_FAST_EN
    logic        fast_hit;
    logic [31:0] fast_res;

    assign fast_hit = (rs1_i == '0) | (rs2_i == '0);

    always_comb begin
        fast_res = '0;
        case (set.mdu_op)
            OP_DIV:  fast_res = (rs2_i == '0) ? 32'hFFFF_FFFF : 32'h0;
            OP_REM:  fast_res = rs1_i;
            default: fast_res = '0;
        endcase
    end
`endif

    // One shared 33-bit adder: add multiplicand for mul, subtract divisor for div.
    logic        is_div;
    logic [32:0] add_a, add_b;
    logic [33:0] add_sum;
    logic        ge;
    logic [63:0] prod_nxt;

    assign is_div = op[1];

    always_comb begin
        add_a = is_div ? prod[63:31] : {1'b0, prod[63:32]};
        add_b = is_div ? ~b_mag : (prod[0] ? b_mag : 33'd0);
        add_sum = {1'b0, add_a} + {1'b0, add_b} + {33'd0, is_div};
        ge = add_sum[33];
        if (is_div)
            prod_nxt = {(ge ? add_sum[31:0] : prod[62:31]), prod[30:0], ge};
        else
            prod_nxt = {add_sum[32:0], prod[31:1]};
    end

    // Sign fix-up applied to the value produced by the final iteration.
    logic        neg_p, b_zero;
    logic [63:0] prod_s;
    logic [31:0] quo, rem, fix_res;

    assign neg_p  = neg_a ^ neg_b;
    assign b_zero = (b_mag == '0);
    assign prod_s = neg_p ? (64'd0 - prod_nxt) : prod_nxt;
    assign quo    = prod_nxt[31:0];
    assign rem    = prod_nxt[63:32];

    always_comb begin
        fix_res = '0;
        case (op)
            OP_MUL:  fix_res = prod_s[31:0];
            OP_MULH: fix_res = prod_s[63:32];
            OP_DIV:  fix_res = (neg_p & ~b_zero) ? (32'd0 - quo) : quo;
            OP_REM:  fix_res = neg_a ? (32'd0 - rem) : rem;
            default: fix_res = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            vld_q <= 1'b0;
        end else begin
            state <= state_nxt;
            vld_q <= vld_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        vld_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef YSYX_24080006_MDU_FAST_EN
                    state_nxt = fast_hit ? DONE : CALC;
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC: begin
                if (flush_i)
                    state_nxt = IDLE;
                else if (cnt == 5'd0)
                    state_nxt = DONE;
            end
            DONE: begin
                // valid rises one cycle after the result register is written
                if (flush_i || (vld_q && out_ready_i))
                    state_nxt = IDLE;
                else
                    vld_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state == IDLE);
        out_valid_o = vld_q;
        result_o    = result_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op       <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            b_mag    <= '0;
            prod     <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else if (accept) begin
            op    <= set.mdu_op;
            neg_a <= neg_a_in;
            neg_b <= neg_b_in;
            b_mag <= b_mag_in;
            prod  <= {32'd0, a_mag_in[31:0]};
            cnt   <= 5'd31;
`ifdef YSYX_24080006_MDU_FAST_EN
            if (fast_hit)
                result_q <= fast_res;
`endif
        end else if (state == CALC && !flush_i) begin
            prod <= prod_nxt;
            cnt  <= cnt - 5'd1;
            if (cnt == 5'd0)
                result_q <= fix_res;
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_mdu.sv
// Self-checking bench for ysyx_24080006_mdu: directed RV32M corner cases plus randomized ops vs. a 64-bit arithmetic model.
module tb_ysyx_24080006_mdu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [4:0]  mdu_set_i = '0;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] result_o;

    int checks = 0;
    int failures = 0;

    localparam logic [1:0] MUL = 2'd0, MULH = 2'd1, DIV = 2'd2, REM = 2'd3;

    ysyx_24080006_mdu #(.XLEN(32)) dut (
        .clock(clock), .reset(reset), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .mdu_set_i(mdu_set_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .result_o(result_o)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_mdu(input logic [1:0] op, input logic sa, input logic sb,
                                            input logic [31:0] a, input logic [31:0] b);
        longint va, vb;
        logic [63:0] p;
        va = sa ? longint'($signed(a)) : longint'(a);
        vb = sb ? longint'($signed(b)) : longint'(b);
        p  = 64'(va * vb);
        case (op)
            MUL:     return p[31:0];
            MULH:    return p[63:32];
            DIV:     return (vb == 0) ? 32'hFFFF_FFFF : 32'(va / vb);
            default: return (vb == 0) ? a : 32'(va % vb);
        endcase
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef YSYX_24080006_MDU_FAST_EN
        return (a == 0 || b == 0) ? 1 : 33;
`else
        return 33;
`endif
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'(($urandom_range(0, 40)));
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a request for one edge, then scramble inputs to show they are not re-sampled.
    task automatic issue(input logic [1:0] op, input logic sa, input logic sb,
                         input logic [31:0] a, input logic [31:0] b, input string name);
        checks++;
        if (in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_before: in_ready_o=%b expected 1", name, in_ready_o);
        end
        in_valid_i = 1'b1;
        mdu_set_i  = {1'b1, sa, sb, op};
        rs1_i = a;
        rs2_i = b;
        step();
        in_valid_i = 1'b0;
        mdu_set_i  = 5'($urandom);
        rs1_i = $urandom;
        rs2_i = $urandom;
        checks++;
        if (in_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_accept: in_ready_o=%b expected 0", name, in_ready_o);
        end
    endtask

    task automatic wait_valid(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b1;
        while (out_valid_o !== 1'b1) begin
            if (lat >= 100) begin
                ok = 1'b0;
                return;
            end
            step();
            lat++;
        end
    endtask

    task automatic collect(input logic [31:0] exp, input int elat, input string name);
        int lat;
        bit ok;
        wait_valid(lat, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout: no out_valid_o within 100 cycles, expected latency %0d", name, elat);
            return;
        end
        if (lat != elat) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles expected %0d", name, lat, elat);
        end
        checks++;
        if (result_o !== exp) begin
            failures++;
            $display("FAIL %s_result: got %h expected %h", name, result_o, exp);
        end
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL %s_xfer: out_valid_o=%b in_ready_o=%b expected 0/1", name, out_valid_o, in_ready_o);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || result_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: ready=%b valid=%b result=%h expected 1/0/00000000",
                     in_ready_o, out_valid_o, result_o);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    typedef struct {
        logic [1:0]  op;
        logic        sa, sb;
        logic [31:0] a, b, exp;
    } vec_t;

    task automatic test_directed();
        vec_t v[12];
        v[0]  = '{MUL,  1, 1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        v[1]  = '{MULH, 1, 1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        v[2]  = '{MULH, 0, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        v[3]  = '{MULH, 1, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        v[4]  = '{DIV,  1, 1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        v[5]  = '{REM,  1, 1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        v[6]  = '{DIV,  0, 0, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC};
        v[7]  = '{DIV,  0, 0, 32'd5,          32'd0,         32'hFFFF_FFFF};
        v[8]  = '{REM,  0, 0, 32'd5,          32'd0,         32'd5};
        v[9]  = '{DIV,  1, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        v[10] = '{REM,  1, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0};
        v[11] = '{REM,  1, 1, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9};
        for (int i = 0; i < 12; i++) begin
            issue(v[i].op, v[i].sa, v[i].sb, v[i].a, v[i].b, $sformatf("dir%0d", i));
            collect(v[i].exp, exp_lat(v[i].a, v[i].b), $sformatf("dir%0d", i));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  op;
            logic        sa, sb;
            logic [31:0] a, b;
            op = 2'($urandom);
            sa = 1'($urandom);
            sb = (op == MULH) ? (sa & 1'($urandom)) : 1'($urandom);
            a  = rnd_opnd();
            b  = rnd_opnd();
            issue(op, sa, sb, a, b, $sformatf("rnd%0d", i));
            collect(ref_mdu(op, sa, sb, a, b), exp_lat(a, b), $sformatf("rnd%0d", i));
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit ok;
        logic [31:0] a, b, held;
        a = $urandom;
        b = $urandom;
        issue(MULH, 1'b1, 1'b1, a, b, "bp");
        wait_valid(lat, ok);
        held = result_o;
        checks++;
        if (!ok || held !== ref_mdu(MULH, 1'b1, 1'b1, a, b)) begin
            failures++;
            $display("FAIL bp_result: ok=%b got %h expected %h", ok, held, ref_mdu(MULH, 1'b1, 1'b1, a, b));
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (out_valid_o !== 1'b1 || result_o !== held || in_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d: valid=%b result=%h ready=%b expected 1/%h/0",
                         i, out_valid_o, result_o, in_ready_o, held);
            end
        end
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: valid=%b ready=%b expected 0/1", out_valid_o, in_ready_o);
        end
        step();
        checks++;
        if (out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_single_xfer: valid=%b expected 0", out_valid_o);
        end
    endtask

    task automatic test_flush();
        int lat;
        bit ok;
        int spurious;
        logic [31:0] a, b;
        // flush during CALC, then next request the following cycle
        issue(DIV, 1'b1, 1'b1, $urandom | 32'h1, 32'd7, "flc");
        repeat (10) step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_calc: valid=%b ready=%b expected 0/1", out_valid_o, in_ready_o);
        end
        a = $urandom;
        b = $urandom | 32'h1;
        issue(REM, 1'b0, 1'b0, a, b, "flc_next");
        collect(ref_mdu(REM, 1'b0, 1'b0, a, b), exp_lat(a, b), "flc_next");
        // flush while result is waiting
        issue(MUL, 1'b0, 1'b0, 32'd3, 32'd5, "fld");
        wait_valid(lat, ok);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) spurious++;
            step();
        end
        checks++;
        if (!ok || spurious != 0) begin
            failures++;
            $display("FAIL flush_done: ok=%b bad_cycles=%0d expected 1/0", ok, spurious);
        end
        // flush with request in IDLE, and disabled request: both ignored
        in_valid_i = 1'b1;
        mdu_set_i  = {1'b1, 1'b0, 1'b0, MUL};
        flush_i    = 1'b1;
        step();
        flush_i = 1'b0;
        checks++;
        if (in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_blocks_accept: ready=%b expected 1", in_ready_o);
        end
        mdu_set_i = {1'b0, 1'b1, 1'b1, DIV};
        step();
        in_valid_i = 1'b0;
        checks++;
        if (in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL enable_low_ignored: ready=%b expected 1", in_ready_o);
        end
        repeat (2) step();
        checks++;
        if (out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL ignored_no_valid: valid=%b expected 0", out_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        int spurious;
        issue(MULH, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5679, "rst");
        repeat (5) step();
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || result_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: ready=%b valid=%b result=%h expected 1/0/00000000",
                     in_ready_o, out_valid_o, result_o);
        end
        step();
        reset = 1'b0;
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL reset_release: bad_cycles=%0d expected 0", spurious);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit ok;
        logic [31:0] a, b, c, d;
        a = $urandom;
        b = $urandom;
        c = $urandom;
        d = $urandom_range(1, 1000);
        issue(MUL, 1'b1, 1'b1, a, b, "b2b_a");
        wait_valid(lat, ok);
        checks++;
        if (!ok || result_o !== ref_mdu(MUL, 1'b1, 1'b1, a, b)) begin
            failures++;
            $display("FAIL b2b_a_result: ok=%b got %h expected %h", ok, result_o, ref_mdu(MUL, 1'b1, 1'b1, a, b));
        end
        // request held high across the transfer cycle must wait for IDLE
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        mdu_set_i   = {1'b1, 1'b0, 1'b0, DIV};
        rs1_i = c;
        rs2_i = d;
        step();
        out_ready_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_no_accept_on_xfer: valid=%b ready=%b expected 0/1", out_valid_o, in_ready_o);
        end
        issue(DIV, 1'b0, 1'b0, c, d, "b2b_b");
        collect(ref_mdu(DIV, 1'b0, 1'b0, c, d), exp_lat(c, d), "b2b_b");
    endtask

    initial begin
        #1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
